// File: rtl/regfile24_wb_arbiter_if.sv
// Writeback arbiter bus: ALU and memory-return request channels, register-file
// write port, and the status outputs used by issue logic.
interface regfile24_wb_arbiter_if #(
   parameter int unsigned FIFO_DEPTH = 4
);
   localparam int unsigned DEST_W = 5;
   localparam int unsigned DATA_W = 24;
   localparam int unsigned NREGS  = 32;
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

   logic              alu_valid_i;
   logic [DEST_W-1:0] alu_dest_i;
   logic [DATA_W-1:0] alu_data_i;
   logic              alu_ready_o;

   logic              mem_valid_i;
   logic [DEST_W-1:0] mem_dest_i;
   logic [DATA_W-1:0] mem_data_i;
   logic              mem_ready_o;

   logic [DEST_W-1:0] dest_o;
   logic [DATA_W-1:0] data_w_o;
   logic              dest_we_o;

   logic [NREGS-1:0]  pending_mask_o;
   logic [CNT_W-1:0]  fifo_count_o;

   // Arbiter side
   modport slave (
      input  alu_valid_i, alu_dest_i, alu_data_i,
      output alu_ready_o,
      input  mem_valid_i, mem_dest_i, mem_data_i,
      output mem_ready_o,
      output dest_o, data_w_o, dest_we_o,
      output pending_mask_o, fifo_count_o
   );

   // Producer / register-file side
   modport master (
      output alu_valid_i, alu_dest_i, alu_data_i,
      input  alu_ready_o,
      output mem_valid_i, mem_dest_i, mem_data_i,
      input  mem_ready_o,
      input  dest_o, data_w_o, dest_we_o,
      input  pending_mask_o, fifo_count_o
   );
endinterface

// File: rtl/regfile24_wb_arbiter.sv
// Writeback arbiter for the 24-bit x 32 control-unit register file.
// ALU writes have priority; memory returns queue in a FIFO and are force-drained
// after STARVE_LIMIT consecutive lost arbitrations.
module regfile24_wb_arbiter #(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                  core_clock_i,
   input  logic                  core_reset_n_i,
   regfile24_wb_arbiter_if.slave wb
);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned DEST_W = 5;
   localparam int unsigned DATA_W = 24;
   localparam int unsigned NREGS  = 32;
   localparam int unsigned STV_W  = 8;

   typedef enum logic {
      ARB_ALU,
      ARB_DRAIN
   } arb_state_e;

   arb_state_e        state_q, state_d;
   logic [DEST_W-1:0] fifo_dest_q [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [STV_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic [DEST_W-1:0] dest_q;
   logic [DATA_W-1:0] data_q;
   logic              we_q;

   logic              fifo_empty;
   logic              fifo_ready;
   logic              push;
   logic              pop;
   logic              alu_grant;
   logic [PTR_W-1:0]  slot_ofs;
   logic [NREGS-1:0]  pending_mask;

   assign fifo_empty = (count_q == '0);
   assign fifo_ready = (count_q != CNT_W'(FIFO_DEPTH));
   assign push       = wb.mem_valid_i && fifo_ready;
   assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

   assign wb.alu_ready_o    = (state_q != ARB_DRAIN);
   assign wb.mem_ready_o    = fifo_ready;
   assign wb.dest_o         = dest_q;
   assign wb.data_w_o       = data_q;
   assign wb.dest_we_o      = we_q;
   assign wb.pending_mask_o = pending_mask;
   assign wb.fifo_count_o   = count_q;

   // Arbitration state register
   always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
      if (!core_reset_n_i) begin
         state_q      <= ARB_ALU;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // Grant selection, starvation tracking and forced-drain entry
   always_comb begin
      state_d      = state_q;
      alu_grant    = 1'b0;
      pop          = 1'b0;
      starve_cnt_d = starve_cnt_q;
      case (state_q)
         ARB_ALU: begin
            if (wb.alu_valid_i) begin
               alu_grant = 1'b1;
            end else if (!fifo_empty) begin
               pop = 1'b1;
            end
         end
         ARB_DRAIN: begin
            pop     = !fifo_empty;
            state_d = ARB_ALU;
         end
         default: state_d = ARB_ALU;
      endcase
      if (pop || fifo_empty) begin
         starve_cnt_d = '0;
      end else if (alu_grant) begin
         starve_cnt_d = starve_cnt_q + STV_W'(1);
      end
      // Counter only reaches the limit while the FIFO is non-empty, so a drain always has an entry
      if (state_q == ARB_ALU && starve_cnt_d == STV_W'(STARVE_LIMIT)) begin
         state_d = ARB_DRAIN;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
      if (!core_reset_n_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   // FIFO storage; validity is tracked by the pointers, so no reset needed
   always_ff @(posedge core_clock_i) begin
      if (push) begin
         fifo_dest_q[wr_ptr_q] <= wb.mem_dest_i;
         fifo_data_q[wr_ptr_q] <= wb.mem_data_i;
      end
   end

   // Registered register-file write port; address/data hold when idle
   always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
      if (!core_reset_n_i) begin
         dest_q <= '0;
         data_q <= '0;
         we_q   <= 1'b0;
      end else begin
         we_q <= alu_grant || pop;
         if (alu_grant) begin
            dest_q <= wb.alu_dest_i;
            data_q <= wb.alu_data_i;
         end else if (pop) begin
            dest_q <= fifo_dest_q[rd_ptr_q];
            data_q <= fifo_data_q[rd_ptr_q];
         end
      end
   end

   // Pending-write mask: OR of one-hot destinations of every occupied slot
   always_comb begin
      pending_mask = '0;
      slot_ofs     = '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
         slot_ofs = PTR_W'(i) - rd_ptr_q;
         if (CNT_W'(slot_ofs) < count_q) begin
            pending_mask[fifo_dest_q[i]] = 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_regfile24_wb_arbiter.sv
// Scoreboard bench for regfile24_wb_arbiter: stimulus pushes expected writes per
// source, a negedge monitor pops and compares every register-file write.
module tb_regfile24_wb_arbiter;
   localparam int unsigned FIFO_DEPTH   = 4;
   localparam int unsigned STARVE_LIMIT = 8;

   typedef struct packed {
      logic [4:0]  dest;
      logic [23:0] data;
   } wb_item_t;

   logic     clk   = 1'b0;
   logic     rst_n = 1'b1;
   int       checks   = 0;
   int       failures = 0;
   wb_item_t alu_src[$];
   wb_item_t mem_src[$];
   wb_item_t exp_alu[$];
   wb_item_t exp_mem[$];
   wb_item_t mon_item;
   logic [23:0] rf [32];

   regfile24_wb_arbiter_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

   regfile24_wb_arbiter #(
      .FIFO_DEPTH  (FIFO_DEPTH),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .core_clock_i  (clk),
      .core_reset_n_i(rst_n),
      .wb            (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic wb_item_t mk(input logic [4:0] d, input logic [23:0] x);
      wb_item_t r;
      r.dest = d;
      r.data = x;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Present the head of each source queue to the DUT
   task automatic drive();
      bus.alu_valid_i = (alu_src.size() != 0);
      if (alu_src.size() != 0) begin
         bus.alu_dest_i = alu_src[0].dest;
         bus.alu_data_i = alu_src[0].data;
      end
      bus.mem_valid_i = (mem_src.size() != 0);
      if (mem_src.size() != 0) begin
         bus.mem_dest_i = mem_src[0].dest;
         bus.mem_data_i = mem_src[0].data;
      end
   endtask

   // Record handshakes completing at the next edge, then advance one cycle
   task automatic settle();
      if (bus.alu_valid_i && bus.alu_ready_o) exp_alu.push_back(alu_src.pop_front());
      if (bus.mem_valid_i && bus.mem_ready_o) exp_mem.push_back(mem_src.pop_front());
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((alu_src.size() + mem_src.size() + exp_alu.size() + exp_mem.size()) != 0 && n < 40) begin
         @(negedge clk);
         settle();
         n++;
      end
      @(negedge clk);
      check({name, "_drained"}, 32'(alu_src.size() + mem_src.size() + exp_alu.size() + exp_mem.size()), 32'd0);
      check({name, "_count_idle"}, 32'(bus.fifo_count_o), 32'd0);
      settle();
   endtask

   // Monitor: ALU data carries top nibble A, memory data never does
   always @(negedge clk) begin
      if (!rst_n) begin
         check("we_in_reset", 32'(bus.dest_we_o), 32'd0);
      end else if (bus.dest_we_o) begin
         rf[bus.dest_o] = bus.data_w_o;
         if (bus.data_w_o[23:20] == 4'hA) begin
            check("alu_wb_expected", 32'(exp_alu.size() != 0), 32'd1);
            if (exp_alu.size() != 0) begin
               mon_item = exp_alu.pop_front();
               check("alu_wb_dest", 32'(bus.dest_o), 32'(mon_item.dest));
               check("alu_wb_data", 32'(bus.data_w_o), 32'(mon_item.data));
            end
         end else begin
            check("mem_wb_expected", 32'(exp_mem.size() != 0), 32'd1);
            if (exp_mem.size() != 0) begin
               mon_item = exp_mem.pop_front();
               check("mem_wb_dest", 32'(bus.dest_o), 32'(mon_item.dest));
               check("mem_wb_data", 32'(bus.data_w_o), 32'(mon_item.data));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog timeout");
   end

   initial begin
      bus.alu_valid_i = 1'b0;
      bus.alu_dest_i  = '0;
      bus.alu_data_i  = '0;
      bus.mem_valid_i = 1'b0;
      bus.mem_dest_i  = '0;
      bus.mem_data_i  = '0;
      #1 rst_n = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_dest_we", 32'(bus.dest_we_o), 32'd0);
      check("rst_dest", 32'(bus.dest_o), 32'd0);
      check("rst_data", 32'(bus.data_w_o), 32'd0);
      check("rst_pending", bus.pending_mask_o, 32'd0);
      check("rst_count", 32'(bus.fifo_count_o), 32'd0);
      check("rst_mem_ready", 32'(bus.mem_ready_o), 32'd1);
      check("rst_alu_ready", 32'(bus.alu_ready_o), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // ALU-only stream, including r0 and r31, then hold on idle
      alu_src.push_back(mk(5'd3, 24'hABCDEF));
      alu_src.push_back(mk(5'd0, 24'hA00000));
      alu_src.push_back(mk(5'd31, 24'hAFFFFF));
      drive();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) begin
            check("alu_ready_n0", 32'(bus.alu_ready_o), 32'd1);
            check("alu_we_n0", 32'(bus.dest_we_o), 32'd0);
         end
         if (i == 1) begin
            check("alu_we_n1", 32'(bus.dest_we_o), 32'd1);
            check("alu_dest_n1", 32'(bus.dest_o), 32'd3);
            check("alu_data_n1", 32'(bus.data_w_o), 32'hABCDEF);
            check("alu_ready_n1", 32'(bus.alu_ready_o), 32'd1);
         end
         if (i == 2) check("alu_dest_r0", 32'(bus.dest_o), 32'd0);
         if (i == 3) check("alu_data_r31", 32'(bus.data_w_o), 32'hAFFFFF);
         if (i == 4) begin
            check("idle_we", 32'(bus.dest_we_o), 32'd0);
            check("idle_dest_hold", 32'(bus.dest_o), 32'd31);
            check("idle_data_hold", 32'(bus.data_w_o), 32'hAFFFFF);
         end
         settle();
      end
      check("rf_r3_readback", 32'(rf[3]), 32'hABCDEF);

      // Memory-only: one entry, two-cycle latency, mask tracks queued entry
      mem_src.push_back(mk(5'd7, 24'h000111));
      drive();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 0) check("mem_mask_n0", bus.pending_mask_o, 32'd0);
         if (i == 1) begin
            check("mem_mask_n1", bus.pending_mask_o, 32'h0000_0080);
            check("mem_count_n1", 32'(bus.fifo_count_o), 32'd1);
            check("mem_we_n1", 32'(bus.dest_we_o), 32'd0);
         end
         if (i == 2) begin
            check("mem_we_n2", 32'(bus.dest_we_o), 32'd1);
            check("mem_dest_n2", 32'(bus.dest_o), 32'd7);
            check("mem_data_n2", 32'(bus.data_w_o), 32'h000111);
            check("mem_mask_n2", bus.pending_mask_o, 32'd0);
         end
         settle();
      end
      wait_idle("mem_only");

      // Fill FIFO under continuous ALU traffic, then forced drain after 8 grants
      for (int k = 0; k < 12; k++) alu_src.push_back(mk(5'(k), 24'hA10000 + 24'(k)));
      for (int k = 0; k < 5; k++) mem_src.push_back(mk(5'(12 + k), 24'h510000 + 24'(k)));
      drive();
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (i <= 12) check($sformatf("starve_alu_ready_c%0d", i), 32'(bus.alu_ready_o), 32'(i != 9));
         if (i == 4) begin
            check("fill_mem_ready", 32'(bus.mem_ready_o), 32'd0);
            check("fill_count", 32'(bus.fifo_count_o), 32'd4);
         end
         if (i == 9) begin
            check("drain_count", 32'(bus.fifo_count_o), 32'd4);
            check("drain_mem_ready", 32'(bus.mem_ready_o), 32'd0);
         end
         if (i == 10) begin
            check("post_drain_count", 32'(bus.fifo_count_o), 32'd3);
            check("post_drain_mem_ready", 32'(bus.mem_ready_o), 32'd1);
            check("drain_write_data", 32'(bus.data_w_o), 32'h510000);
         end
         if (i == 11) begin
            check("held_alu_we", 32'(bus.dest_we_o), 32'd1);
            check("held_alu_data", 32'(bus.data_w_o), 32'hA10009);
         end
         if (i == 12) check("refill_count", 32'(bus.fifo_count_o), 32'd4);
         settle();
      end
      wait_idle("starve");

      // Push and pop together at count 2 across pointer wrap, duplicate dest in mask
      for (int k = 0; k < 2; k++) alu_src.push_back(mk(5'd1, 24'hA20000 + 24'(k)));
      mem_src.push_back(mk(5'd5, 24'h520000));
      mem_src.push_back(mk(5'd5, 24'h520001));
      mem_src.push_back(mk(5'd9, 24'h520002));
      for (int k = 3; k < 10; k++) mem_src.push_back(mk(5'(20 + k), 24'h520000 + 24'(k)));
      drive();
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         if (i == 0) check("pp_count_c0", 32'(bus.fifo_count_o), 32'd0);
         if (i == 1) check("pp_count_c1", 32'(bus.fifo_count_o), 32'd1);
         if (i >= 2) check($sformatf("pp_count_c%0d", i), 32'(bus.fifo_count_o), 32'd2);
         if (i == 2) check("dup_mask_both", bus.pending_mask_o, 32'h0000_0020);
         if (i == 3) check("dup_mask_last", bus.pending_mask_o, 32'h0000_0220);
         if (i == 4) check("mask_after_dup", bus.pending_mask_o, 32'h0080_0200);
         settle();
      end
      wait_idle("push_pop");

      // Asynchronous reset with three entries queued and a write in flight
      for (int k = 0; k < 6; k++) alu_src.push_back(mk(5'd2, 24'hA30000 + 24'(k)));
      for (int k = 0; k < 3; k++) mem_src.push_back(mk(5'(15 + k), 24'h530000 + 24'(k)));
      drive();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         settle();
      end
      @(negedge clk);
      check("pre_rst_count", 32'(bus.fifo_count_o), 32'd3);
      check("pre_rst_mask", bus.pending_mask_o, 32'h0003_8000);
      #2;
      rst_n = 1'b0;
      alu_src.delete();
      mem_src.delete();
      exp_alu.delete();
      exp_mem.delete();
      drive();
      #1;
      check("async_rst_count", 32'(bus.fifo_count_o), 32'd0);
      check("async_rst_mask", bus.pending_mask_o, 32'd0);
      check("async_rst_we", 32'(bus.dest_we_o), 32'd0);
      check("async_rst_mem_ready", 32'(bus.mem_ready_o), 32'd1);
      check("async_rst_alu_ready", 32'(bus.alu_ready_o), 32'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("post_rst_no_write", 32'(bus.dest_we_o), 32'd0);
      end
      check("post_rst_count", 32'(bus.fifo_count_o), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/regfile24_wb_arbiter.md
Name: regfile24_wb_arbiter

Overview:
- Writeback arbiter that sits directly upstream of the 24-bit, 32-entry control-unit register file and drives its single write port.
- Two producers share that port: the scalar ALU, which is single-cycle and has priority, and the memory/load return path, which is buffered in a small FIFO.
- A starvation counter guarantees that load returns drain.
- The block exports a pending-write mask so that issue logic can hold off reads or writes to registers with queued load data.

Parameters:
- FIFO_DEPTH, 4, number of buffered memory writebacks; must be a power of 2, ≥2.
- STARVE_LIMIT, 8, consecutive cycles the non-empty FIFO may lose arbitration before a forced drain; range 1..255.

Ports:
- core_clock_i  in  1  clock; all state updates on the rising edge.
- core_reset_n_i  in  1  asynchronous active-low reset.
- alu_valid_i  in  1  ALU writeback request.
- alu_dest_i  in  5  ALU destination register.
- alu_data_i  in  24  ALU write data.
- alu_ready_o  out  1  ALU write accepted this cycle.
- mem_valid_i  in  1  memory-return writeback request.
- mem_dest_i  in  5  memory destination register.
- mem_data_i  in  24  memory write data.
- mem_ready_o  out  1  FIFO can accept an entry this cycle.
- dest_o  out  5  register-file write address.
- data_w_o  out  24  register-file write data.
- dest_we_o  out  1  register-file write enable.
- pending_mask_o  out  32  bit r set if any valid FIFO entry targets register r.
- fifo_count_o  out  log2(FIFO_DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FIFO empty, read/write pointers 0, starve_cnt 0, state ARB_ALU.
  - dest_o=0, data_w_o=0, dest_we_o=0.
  - Hence pending_mask_o=0, fifo_count_o=0, mem_ready_o=1, alu_ready_o=1.
- Reset mid-operation discards all queued entries and any in-flight write. No write is emitted while reset is asserted.
- Memory handshake:
  - The transfer occurs when mem_valid_i & mem_ready_o.
  - mem_ready_o = (count != FIFO_DEPTH). It does not depend on a same-cycle pop.
  - mem_valid_i, mem_dest_i and mem_data_i must be held until the transfer. A push and a pop in the same cycle is legal at any non-full count.
- ALU handshake:
  - The ALU write is taken when alu_valid_i & alu_ready_o.
  - alu_ready_o is combinational: 0 only in state ARB_DRAIN, 1 otherwise.
- Arbitration, per cycle:
  - ARB_ALU: if alu_valid_i, grant the ALU. Otherwise, if the FIFO is non-empty, grant the FIFO head and pop it. Otherwise there is no grant.
  - ARB_DRAIN: grant the FIFO head and pop it. alu_valid_i is ignored, with no grant and no loss, since the ALU holds its request.
- Output register:
  - The granted dest and data are registered. dest_we_o=1 in the following cycle.
  - With no grant, dest_we_o=0 and dest_o/data_w_o hold their previous values.
  - ALU latency: request in cycle N gives dest_we_o in cycle N+1.
  - Memory latency: accepted in cycle N, FIFO head in N+1; if granted in N+1, dest_we_o in N+2.
- Starvation:
  - starve_cnt (8-bit) increments when the FIFO is non-empty and the ALU is granted.
  - It clears to 0 on any FIFO pop or whenever the FIFO is empty.
  - When starve_cnt == STARVE_LIMIT at a clock edge, the next state is ARB_DRAIN.
  - ARB_DRAIN lasts exactly one cycle: pop one entry, clear starve_cnt, return to ARB_ALU.
- pending_mask_o:
  - Combinational OR over valid FIFO entries of a one-hot decode of dest. It excludes the registered output stage.
  - Duplicate destinations in the FIFO keep the bit set until the last of them pops.
- FIFO ordering is strict: entries drain in acceptance order.
  - Same-register ordering between the ALU and memory paths is the issue logic's responsibility, using pending_mask_o.
  - The arbiter writes in grant order; the later write wins in the register file.
- Pointers wrap modulo FIFO_DEPTH. count uses an extra bit to distinguish full from empty.
- No register is special: writes to r0 pass through unchanged.

Test Plan:
- Reset, then ALU-only stream:
  - alu_valid_i=1, dest=3, data=24'hABCDEF in cycle N → dest_we_o=1, dest_o=3, data_w_o=24'hABCDEF in N+1.
  - alu_ready_o stays 1; the register file reads back 24'hABCDEF.
- Memory-only:
  - Push dest=7/24'h000111 in cycle N → pending_mask_o[7]=1 in N+1; dest_we_o with dest 7 in N+2; pending_mask_o=0 in N+2.
- Fill FIFO:
  - Hold alu_valid_i=1 and push 5 memory entries → mem_ready_o=0 after 4; fifo_count_o=4; 5th entry stalls until a pop.
- Starvation (STARVE_LIMIT=8):
  - ALU valid every cycle, FIFO non-empty → after 8 ALU grants, alu_ready_o=0 for exactly 1 cycle.
  - One FIFO entry is written and fifo_count_o decrements; the ALU resumes the next cycle with its held request written.
- Simultaneous push and pop at count=2, plus pointer wrap:
  - count stays 2; after 10 entries total, drain order matches acceptance order.
- Reset asserted mid-stream with 3 entries queued:
  - fifo_count_o=0, pending_mask_o=0, dest_we_o=0 immediately (asynchronous).
  - No stale write is seen after release.
